hourglass_core: RTL and testbench

- Consumer end of the divider's selected-speed clock output: turns that slow square wave into a sand-transfer model for the electronic hourglass.
- Runs on the 1 MHz system clock and treats the divided clock as an asynchronous level input.
- Synchronizes the level input, converts each rising edge into a one-cycle grain strobe, and moves one grain per strobe from the top chamber to the bottom chamber.
- Drives chamber counts to the display logic, plus status flags.

---
 rtl/hg_pkg.sv | 20 ++
 rtl/hg_edge_sync.sv | 29 ++
 rtl/hourglass_core.sv | 135 +++++++++++++
 tb/tb_hourglass_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hg_pkg.sv
// Shared types and constants for the electronic hourglass core.
package hg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } hg_state_e;

    localparam int HG_GRAINS     = 60;
    localparam int HG_BEEP_TICKS = 4;

    // Strobe priority within a single cycle, 0 = highest. A losing tick is dropped.
    localparam int PRIO_FLIP  = 0;
    localparam int PRIO_PAUSE = 1;
    localparam int PRIO_TICK  = 2;
    localparam int PRIO_START = 3;

endpackage

// File: rtl/hg_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge strobe.
module hg_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            s1_reg   <= d;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    assign level = s2_reg;
    assign rise  = s2_reg & ~prev_reg;

endmodule

// File: rtl/hourglass_core.sv
// Hourglass sand-transfer model: one grain moves top->bottom per synchronized tick edge.
// Optional end-of-run buzzer is built only when HG_BEEP_EN is defined.
import hg_pkg::*;

module hourglass_core #(
    parameter int GRAINS     = HG_GRAINS,
    parameter int CW         = 6,
    parameter int BEEP_TICKS = HG_BEEP_TICKS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    input  logic          start,
    input  logic          flip,
    input  logic          pause,
    output logic [CW-1:0] top_cnt,
    output logic [CW-1:0] bot_cnt,
    output logic          running,
    output logic          done,
    output logic          beep
);

    logic tick_s, start_s, flip_s, pause_l;
    logic tick_lvl, start_lvl, flip_lvl, pause_rise;
    logic unused_sync;

    hg_edge_sync u_tick  (.clk(clk), .rst(rst), .d(tick_in), .level(tick_lvl),  .rise(tick_s));
    hg_edge_sync u_start (.clk(clk), .rst(rst), .d(start),   .level(start_lvl), .rise(start_s));
    hg_edge_sync u_flip  (.clk(clk), .rst(rst), .d(flip),    .level(flip_lvl),  .rise(flip_s));
    hg_edge_sync u_pause (.clk(clk), .rst(rst), .d(pause),   .level(pause_l),   .rise(pause_rise));

    assign unused_sync = ^{tick_lvl, start_lvl, flip_lvl, pause_rise};

    hg_state_e     state_reg, state_next;
    logic [CW-1:0] top_reg, top_next;
    logic [CW-1:0] bot_reg, bot_next;
    logic          running_reg, running_next;
    logic          done_reg, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            top_reg     <= CW'(GRAINS);
            bot_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            top_reg     <= top_next;
            bot_reg     <= bot_next;
            running_reg <= running_next;
            done_reg    <= done_next;
        end
    end

    // A flip pre-empts everything else in the cycle, so it is resolved first.
    always_comb begin
        state_next = state_reg;
        top_next   = top_reg;
        bot_next   = bot_reg;
        if (flip_s) begin
            top_next = bot_reg;
            bot_next = top_reg;
            case (state_reg)
                ST_RUN, ST_PAUSED: if (bot_reg == '0) state_next = ST_DONE;
                ST_DONE:           state_next = (bot_reg != '0) ? ST_RUN : ST_DONE;
                default:           state_next = state_reg;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: if (start_s) state_next = ST_RUN;
                ST_RUN: begin
                    if (pause_l) begin
                        state_next = ST_PAUSED;
                    end else if (tick_s && top_reg != '0) begin
                        top_next = top_reg - CW'(1);
                        bot_next = bot_reg + CW'(1);
                        if (top_reg == CW'(1)) state_next = ST_DONE;
                    end
                end
                ST_PAUSED: if (!pause_l && start_s) state_next = ST_RUN;
                default:   state_next = state_reg;
            endcase
        end
    end

    // Only a run that drains by ticking announces completion; a flip into DONE stays silent.
    always_comb begin
        running_next = (state_next == ST_RUN);
        done_next    = (state_reg == ST_RUN) && (state_next == ST_DONE) && !flip_s;
    end

    assign top_cnt = top_reg;
    assign bot_cnt = bot_reg;
    assign running = running_reg;
    assign done    = done_reg;

`ifdef HG_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);

    logic [BW-1:0] bcnt_reg, bcnt_next;
    logic          beep_reg, beep_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_reg <= '0;
            beep_reg <= 1'b0;
        end else begin
            bcnt_reg <= bcnt_next;
            beep_reg <= beep_next;
        end
    end

    always_comb begin
        bcnt_next = bcnt_reg;
        beep_next = beep_reg;
        if (flip_s) begin
            beep_next = 1'b0;
        end else if (done_next) begin
            beep_next = 1'b1;
            bcnt_next = '0;
        end else if (beep_reg && tick_s) begin
            bcnt_next = bcnt_reg + BW'(1);
            if (bcnt_reg == BW'(BEEP_TICKS - 1)) beep_next = 1'b0;
        end
    end

    assign beep = beep_reg;
`else
    logic [31:0] unused_beep_ticks;
    assign unused_beep_ticks = BEEP_TICKS;
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_hourglass_core.sv
// Self-checking bench for hourglass_core: directed scenarios plus random input waveforms
// compared every cycle against a behavioural hourglass model.
module tb_hourglass_core;

    localparam int G  = 60;
    localparam int CW = 6;
    localparam int BT = 4;
`ifdef HG_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0, start = 1'b0, flip = 1'b0, pause = 1'b0;
    logic [CW-1:0] top_cnt, bot_cnt;
    logic          running, done, beep;

    int passed = 0;
    int total = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;

    hourglass_core #(.GRAINS(G), .CW(CW), .BEEP_TICKS(BT)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .flip(flip), .pause(pause),
        .top_cnt(top_cnt), .bot_cnt(bot_cnt), .running(running), .done(done), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a strobe is seen two edges after the input is sampled high,
    // provided the sample one edge earlier was low.
    int m_top = G, m_bot = 0, m_state = M_IDLE, m_bcnt = 0;
    bit m_done = 0, m_beep = 0;
    bit [2:0] h_tick = 0, h_start = 0, h_flip = 0, h_pause = 0;

    always @(posedge clk) begin
        bit ts, ss, fs, pl;
        int tmp;
        if (!rst) begin
            m_top = G; m_bot = 0; m_state = M_IDLE; m_done = 0; m_beep = 0; m_bcnt = 0;
            h_tick = 0; h_start = 0; h_flip = 0; h_pause = 0;
        end else begin
            ts = h_tick[1]  & ~h_tick[2];
            ss = h_start[1] & ~h_start[2];
            fs = h_flip[1]  & ~h_flip[2];
            pl = h_pause[1];
            m_done = 0;
            if (fs) m_beep = 0;
            else if (m_beep && ts) begin
                m_bcnt++;
                if (m_bcnt == BT) m_beep = 0;
            end
            if (fs) begin
                tmp = m_top; m_top = m_bot; m_bot = tmp;
                if (m_state == M_DONE) m_state = (m_top > 0) ? M_RUN : M_DONE;
                else if (m_state != M_IDLE && m_top == 0) m_state = M_DONE;
            end else if (m_state == M_IDLE) begin
                if (ss) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (pl) m_state = M_PAUSED;
                else if (ts && m_top > 0) begin
                    m_top--; m_bot++;
                    if (m_top == 0) begin
                        m_state = M_DONE; m_done = 1;
                        if (BEEP_ON) begin m_beep = 1; m_bcnt = 0; end
                    end
                end
            end else if (m_state == M_PAUSED) begin
                if (!pl && ss) m_state = M_RUN;
            end
            h_tick  = {h_tick[1:0],  tick_in};
            h_start = {h_start[1:0], start};
            h_flip  = {h_flip[1:0],  flip};
            h_pause = {h_pause[1:0], pause};
        end
        #1;
        if (chk_en) begin
            check("top_cnt", int'(top_cnt), m_top);
            check("bot_cnt", int'(bot_cnt), m_bot);
            check("running", int'(running), int'(m_state == M_RUN));
            check("done",    int'(done),    int'(m_done));
            check("beep",    int'(beep),    int'(m_beep));
            if (done) done_seen++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit t, input bit s, input bit f);
        @(negedge clk);
        tick_in = t; start = s; flip = f;
        hold(4);
        tick_in = 0; start = 0; flip = 0;
        hold(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(1, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        hold(2);
        rst = 1;
        hold(2);
    endtask

    task automatic pin(input string name, input int t, input int b, input int r);
        check({name, "_top"}, int'(top_cnt), t);
        check({name, "_bot"}, int'(bot_cnt), b);
        check({name, "_running"}, int'(running), r);
    endtask

    initial begin
        int ds;
        #2 rst = 0;
        hold(2);
        rst = 1;
        chk_en = 1;
        pin("reset", 60, 0, 0);
        check("reset_done", int'(done), 0);
        check("reset_beep", int'(beep), 0);

        // Full run to DONE
        pulse(0, 1, 0);
        check("start_running", int'(running), 1);
        ticks(60);
        pin("full_run", 0, 60, 0);
        check("full_run_done_once", done_seen, 1);
        pulse(0, 0, 1);
        pin("flip_from_done", 60, 0, 1);

        // Pause freezes counts; only start resumes
        do_reset();
        pulse(0, 1, 0);
        ticks(20);
        pin("pre_pause", 40, 20, 1);
        @(negedge clk) pause = 1;
        hold(4);
        ticks(5);
        pin("paused", 40, 20, 0);
        @(negedge clk) pause = 0;
        hold(4);
        check("release_alone", int'(running), 0);
        pulse(0, 1, 0);
        ticks(1);
        pin("resumed", 39, 21, 1);

        // Flip mid-run
        do_reset();
        pulse(0, 1, 0);
        ticks(10);
        pin("pre_flip", 50, 10, 1);
        pulse(0, 0, 1);
        pin("post_flip", 10, 50, 1);
        ds = done_seen;
        ticks(10);
        pin("flip_drain", 0, 60, 0);
        check("flip_drain_done", done_seen - ds, 1);

        // Tick and flip in the same cycle: tick dropped
        do_reset();
        pulse(0, 1, 0);
        ticks(30);
        pulse(1, 0, 1);
        pin("tick_flip", 30, 30, 1);
        ticks(1);
        pin("after_tick_flip", 29, 31, 1);

        // Asynchronous reset mid-run, released with tick_in high
        do_reset();
        pulse(0, 1, 0);
        ticks(43);
        pin("pre_rst", 17, 43, 1);
        @(negedge clk);
        #3 rst = 0;
        #1;
        pin("async_rst", 60, 0, 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_beep", int'(beep), 0);
        tick_in = 1;
        hold(2);
        rst = 1;
        hold(10);
        pin("rst_release", 60, 0, 0);
        tick_in = 0;
        hold(4);

`ifdef HG_BEEP_EN
        do_reset();
        pulse(0, 1, 0);
        ticks(60);
        check("beep_on", int'(beep), 1);
        ticks(3);
        check("beep_3", int'(beep), 1);
        ticks(1);
        check("beep_off", int'(beep), 0);
        do_reset();
        pulse(0, 1, 0);
        ticks(61);
        check("beep_before_flip", int'(beep), 1);
        pulse(0, 0, 1);
        check("beep_flip_clear", int'(beep), 0);
        pin("beep_flip", 60, 0, 1);
`endif

        // Random waveforms, including short glitches, coincident strobes and resets
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            if ($urandom_range(0, 19) == 0) start = ~start;
            if ($urandom_range(0, 79) == 0) flip = ~flip;
            if ($urandom_range(0, 59) == 0) pause = ~pause;
            rst = ($urandom_range(0, 1999) != 0);
        end
        rst = 1;
        hold(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
